// File: rtl/seq_normalize32.sv
// Sequential 32-bit normalizer: a five-step binary search (16/8/4/2/1) that strips
// leading zeros (unsigned) or redundant sign bits (signed), one step per clock.
module seq_normalize32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in,
  input  logic        signed_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic [4:0]  shAmt,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] work_q;
  logic [4:0]  cnt_q;
  logic [2:0]  step_q;
  logic        mode_q;
  logic        zop_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] out_q;
  logic [4:0]  sh_q;
  logic        zero_q;

  logic [5:0]  step_n_s;
  logic [31:0] mask_u_s;
  logic [31:0] mask_s_s;
  logic        hit_s;
  logic [31:0] work_d;
  logic [4:0]  cnt_d;

  // One search step: test the top n (unsigned) or n+1 (signed) bits and shift on a hit
  always_comb begin
    step_n_s = 6'd16 >> step_q;
    mask_u_s = ~(32'hFFFF_FFFF >> step_n_s);
    mask_s_s = ~(32'hFFFF_FFFF >> (step_n_s + 6'd1));
    hit_s    = 1'b0;
    if (mode_q) begin
      hit_s = ((work_q & mask_s_s) == 32'd0) || ((work_q & mask_s_s) == mask_s_s);
    end else begin
      hit_s = ((work_q & mask_u_s) == 32'd0);
    end
    work_d = work_q;
    cnt_d  = cnt_q;
    if (hit_s) begin
      work_d = work_q << step_n_s;
      cnt_d  = cnt_q + step_n_s[4:0];
    end else begin
      work_d = work_q;
      cnt_d  = cnt_q;
    end
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= 32'd0;
      cnt_q   <= 5'd0;
      step_q  <= 3'd0;
      mode_q  <= 1'b0;
      zop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 32'd0;
      sh_q    <= 5'd0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q  <= in;
            cnt_q   <= 5'd0;
            step_q  <= 3'd0;
            mode_q  <= signed_mode;
            zop_q   <= (in == 32'd0);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_d;
          if (step_q == 3'd4) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            // A zero operand would otherwise report the full 31-bit search
            out_q   <= zop_q ? 32'd0 : work_d;
            sh_q    <= zop_q ? 5'd0 : cnt_d;
            zero_q  <= zop_q;
          end else begin
            step_q  <= step_q + 3'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign shAmt = sh_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_seq_normalize32.sv
// Directed bench for seq_normalize32: latency, search results, zero override,
// held-start throughput and reset abort.
module tb_seq_normalize32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] op_in;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic [4:0]  shAmt;
  logic        zero;

  int errors = 0;
  int checks = 0;

  seq_normalize32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(op_in), .signed_mode(signed_mode),
    .busy(busy), .done(done), .out(out), .shAmt(shAmt), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_in = 32'd0; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, zero, shAmt, out} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b zero=%0b shAmt=%0d out=%h, want all 0",
               busy, done, zero, shAmt, out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Start in cycle 0; cycle c is observed at the c-th following negedge.
  task automatic run_op(input string nm, input logic [31:0] op, input logic md,
                        input logic [31:0] eo, input logic [4:0] es, input logic ez);
    @(negedge clk);
    start = 1'b1; op_in = op; signed_mode = md;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) begin op_in = ~op; signed_mode = ~md; end
      checks++;
      if (busy !== (c <= 6)) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %0b want %0b", nm, c, busy, (c <= 6));
      end
      checks++;
      if (done !== (c == 6)) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %0b want %0b", nm, c, done, (c == 6));
      end
      if (c >= 6) begin
        checks++;
        if (out !== eo || shAmt !== es || zero !== ez) begin
          errors++;
          $display("FAIL %s result cycle %0d: got out=%h shAmt=%0d zero=%0b want out=%h shAmt=%0d zero=%0b",
                   nm, c, out, shAmt, zero, eo, es, ez);
        end
      end
    end
  endtask

  task automatic test_unsigned();
    run_op("u_one",    32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    run_op("u_00F0",   32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0);
    run_op("u_msb",    32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0);
    run_op("u_ffff",   32'h0000_FFFF, 1'b0, 32'hFFFF_0000, 5'd16, 1'b0);
  endtask

  task automatic test_signed();
    run_op("s_ffff8000", 32'hFFFF_8000, 1'b1, 32'h8000_0000, 5'd16, 1'b0);
    run_op("s_one",      32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0);
    run_op("s_allones",  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0);
    run_op("s_7fff",     32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 5'd0,  1'b0);
  endtask

  task automatic test_zero();
    run_op("u_zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0, 1'b1);
    run_op("s_zero", 32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0, 1'b1);
  endtask

  // start held high with a new operand every cycle: accepted at 0, 7, 14
  task automatic test_back_to_back();
    logic [31:0] vec [0:20];
    int          ndone;
    for (int i = 0; i <= 20; i++) vec[i] = 32'h1234_5678 + 32'(i);
    vec[0]  = 32'h0000_0001;
    vec[7]  = 32'h00F0_0000;
    vec[14] = 32'h8000_0000;
    ndone = 0;
    @(negedge clk);
    signed_mode = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      if (done === 1'b1) ndone++;
      if (c == 6) begin
        checks++;
        if (done !== 1'b1 || out !== 32'h8000_0000 || shAmt !== 5'd31) begin
          errors++;
          $display("FAIL b2b_first: got done=%0b out=%h shAmt=%0d want 1 80000000 31", done, out, shAmt);
        end
      end
      if (c == 13) begin
        checks++;
        if (done !== 1'b1 || out !== 32'hF000_0000 || shAmt !== 5'd8) begin
          errors++;
          $display("FAIL b2b_second: got done=%0b out=%h shAmt=%0d want 1 f0000000 8", done, out, shAmt);
        end
      end
      if (c == 20) begin
        checks++;
        if (done !== 1'b1 || out !== 32'h8000_0000 || shAmt !== 5'd0) begin
          errors++;
          $display("FAIL b2b_third: got done=%0b out=%h shAmt=%0d want 1 80000000 0", done, out, shAmt);
        end
      end
      start = 1'b1;
      op_in = vec[c];
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 3", ndone);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int ndone;
    ndone = 0;
    @(negedge clk);
    start = 1'b1; op_in = 32'h0000_0001; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0 || {busy, zero, shAmt, out} !== 39'd0) begin
      errors++;
      $display("FAIL abort: got done_pulses=%0d busy=%0b zero=%0b shAmt=%0d out=%h want 0",
               ndone, busy, zero, shAmt, out);
    end
    // start coinciding with reset is dropped
    rst_n = 1'b0; start = 1'b1; op_in = 32'h0000_0001;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_reset: got busy=%0b want 0", busy);
    end
    run_op("post_reset", 32'hFFFF_8000, 1'b1, 32'h8000_0000, 5'd16, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
